// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter slice.
// Optional macro CDB_BYPASS_EN (used by cdb_rr_arbiter) lets an idle channel skip its FIFO.
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_MAX_CH = 32;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_TAG_W-1:0]  tag;
  } cdb_entry_t;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [CDB_MAX_CH-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t r;
    logic [4:0] c;
    r = '0;
    for (int unsigned k = 0; k < CDB_MAX_CH; k++) begin
      if (k < n) begin
        c = 5'((ptr + k) % n);
        if (!r.found && req[c]) begin
          r.found = 1'b1;
          r.idx   = 32'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_fifo.sv
// Per-channel result FIFO; count-based full/empty so ready never depends on the pop.
// Shared by both CDB_BYPASS_EN builds of cdb_rr_arbiter.
module result_fifo import cdb_pkg::*; #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = cdb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_entry,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter: N_CH result FIFOs, one registered broadcast per cycle.
// Define CDB_BYPASS_EN to let a channel with an empty FIFO drive the CDB directly.
module cdb_rr_arbiter import cdb_pkg::*; #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int BUF_DEPTH = 2,
  parameter int SRC_W     = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH*TAG_W-1:0]  ch_tag,
  output logic [N_CH-1:0]        ch_ready,
  output logic                   cdb_valid,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [SRC_W-1:0]       cdb_src
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t           in_entry [N_CH];
  entry_t           head     [N_CH];
  entry_t           win_entry;
  logic [N_CH-1:0]  empty, full, push, pop, req;
  logic [SRC_W-1:0] rr_ptr, win_src;
  logic             grant;
  rr_pick_t         pick;

  assign ch_ready = ~full;

`ifdef CDB_BYPASS_EN
  logic [N_CH-1:0] byp_req, byp_win;
  assign byp_req = empty & ch_valid & ~full;
  assign req     = ~empty | byp_req;
`else
  assign req     = ~empty;
`endif

  always_comb pick = rr_pick(CDB_MAX_CH'(req), 32'(rr_ptr), N_CH);

  assign grant   = pick.found && !flush;
  assign win_src = SRC_W'(pick.idx);

  always_comb begin
    win_entry = '0;
    pop       = '0;
`ifdef CDB_BYPASS_EN
    byp_win   = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (grant && win_src == SRC_W'(i)) begin
        pop[i]    = ~empty[i];
        win_entry = head[i];
`ifdef CDB_BYPASS_EN
        if (empty[i]) begin
          win_entry  = in_entry[i];
          byp_win[i] = 1'b1;
        end
`endif
      end
    end
  end

  // A bypassed winner is consumed by the CDB, so it must not also land in its FIFO.
`ifdef CDB_BYPASS_EN
  assign push = ch_valid & ~full & ~{N_CH{flush}} & ~byp_win;
`else
  assign push = ch_valid & ~full & ~{N_CH{flush}};
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign in_entry[i] = {ch_data[i*DATA_W +: DATA_W], ch_tag[i*TAG_W +: TAG_W]};

    result_fifo #(
      .DEPTH   (BUF_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .push     (push[i]),
      .pop      (pop[i]),
      .wr_entry (in_entry[i]),
      .head     (head[i]),
      .empty    (empty[i]),
      .full     (full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (grant) begin
      cdb_valid <= 1'b1;
      cdb_data  <= win_entry.data;
      cdb_tag   <= win_entry.tag;
      cdb_src   <= win_src;
      rr_ptr    <= (win_src == SRC_W'(N_CH-1)) ? '0 : win_src + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule
